// File: rtl/cal_gen.sv
// cal_gen -- calibration square-wave generator.
//
// Produces a registered square wave on `cal` whose half-period is (P+1)
// clk_sys cycles. P is the active divider, reloaded from a shadow register
// at start and at every full-period boundary (end of the low phase), so a
// new divider written with cal_load mid-period takes effect cleanly on the
// next period. When cal_load coincides with a reload, the incoming
// cal_para is used directly.
//
// Optional feature macro: CAL_GEN_BURST_EN
//   defined   -> cal_mode=1 runs a burst of cal_burst full periods, then
//                returns to IDLE with a one-cycle cal_done pulse.
//   undefined -> every start is continuous; cal_mode/cal_burst are ignored
//                and cal_done is tied low.
//
// Ports:
//   clk_sys    in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   cal_load   in   strobe: latch cal_para into the shadow divider
//   cal_para   in   [DIV_W] half-period minus one
//   cal_mode   in   0 = continuous, 1 = burst (sampled at start)
//   cal_burst  in   [CNT_W] burst length in full periods (sampled at start)
//   cal_start  in   start strobe (ignored while running)
//   cal_stop   in   abort strobe (wins over cal_start)
//   cal        out  square wave
//   cal_busy   out  high while running
//   cal_done   out  one-cycle pulse at burst completion
module cal_gen #(
    parameter int DIV_W = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             cal_load,
    input  logic [DIV_W-1:0] cal_para,
    input  logic             cal_mode,
    input  logic [CNT_W-1:0] cal_burst,
    input  logic             cal_start,
    input  logic             cal_stop,
    output logic             cal,
    output logic             cal_busy,
    output logic             cal_done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [DIV_W-1:0] shadow;
    logic [DIV_W-1:0] p_div;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] next_para;
    logic             start_ok;
    logic             at_limit;
    logic             period_end;
    logic             burst_empty;
    logic             burst_last;

    // Reload source: a coincident cal_load bypasses the shadow register.
    assign next_para  = cal_load ? cal_para : shadow;
    assign start_ok   = (state == IDLE) && cal_start && !cal_stop;
    assign at_limit   = (div_cnt == p_div);
    assign period_end = (state == RUN) && at_limit && !cal;

`ifdef CAL_GEN_BURST_EN
    logic [CNT_W-1:0] pcnt;
    logic             burst_run;
    logic             done_r;

    assign cal_done    = done_r;
    // A zero-length burst never enters RUN; it only pulses cal_done.
    assign burst_empty = cal_mode && (cal_burst == '0);
    // The counter would reach zero at this boundary: the burst is over.
    assign burst_last  = burst_run && (pcnt == CNT_W'(1));

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            pcnt      <= '0;
            burst_run <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start_ok) begin
                if (burst_empty) begin
                    done_r <= 1'b1;
                end else begin
                    burst_run <= cal_mode;
                    pcnt      <= cal_burst;
                end
            end else if ((state == RUN) && cal_stop) begin
                burst_run <= 1'b0;
                pcnt      <= '0;
            end else if (period_end && burst_run) begin
                if (burst_last) begin
                    done_r    <= 1'b1;
                    burst_run <= 1'b0;
                    pcnt      <= '0;
                end else begin
                    pcnt <= pcnt - CNT_W'(1);
                end
            end
        end
    end
`else
    logic unused_burst_inputs;

    assign unused_burst_inputs = cal_mode ^ (^cal_burst);
    assign cal_done            = 1'b0;
    assign burst_empty         = 1'b0;
    assign burst_last          = 1'b0;
`endif

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state    <= IDLE;
            cal      <= 1'b0;
            cal_busy <= 1'b0;
            shadow   <= '0;
            p_div    <= '0;
            div_cnt  <= '0;
        end else begin
            if (cal_load) begin
                shadow <= cal_para;
            end
            if (state == IDLE) begin
                if (start_ok && !burst_empty) begin
                    state    <= RUN;
                    cal      <= 1'b1;
                    cal_busy <= 1'b1;
                    p_div    <= next_para;
                    div_cnt  <= '0;
                end
            end else begin
                if (cal_stop) begin
                    state    <= IDLE;
                    cal      <= 1'b0;
                    cal_busy <= 1'b0;
                    div_cnt  <= '0;
                end else if (at_limit) begin
                    div_cnt <= '0;
                    if (cal) begin
                        cal <= 1'b0;
                    end else if (burst_last) begin
                        state    <= IDLE;
                        cal_busy <= 1'b0;
                    end else begin
                        // Full-period boundary: start next high phase with
                        // the freshest divider value.
                        cal   <= 1'b1;
                        p_div <= next_para;
                    end
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
        end
    end

endmodule
